// File: rtl/kernel_ddr3_mem_dmaster_bytes_to_packets.sv
// Byte-stream to packet-stream decoder: 0x7A/0x7B framing, 0x7C channel, 0x7D escape.
// Optional channel decoding enabled by macro KERNEL_DDR3_MEM_DMASTER_B2P_CHANNEL_EN.
module kernel_ddr3_mem_dmaster_bytes_to_packets #(
    parameter int CHANNEL_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic [CHANNEL_W-1:0] out_channel,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket
);

    localparam logic [1:0] ST_NORMAL   = 2'd0;
    localparam logic [1:0] ST_ESC      = 2'd1;
    localparam logic [1:0] ST_CHAN     = 2'd2;
    localparam logic [1:0] ST_CHAN_ESC = 2'd3;

    localparam logic [7:0] SOP_CODE  = 8'h7A;
    localparam logic [7:0] EOP_CODE  = 8'h7B;
    localparam logic [7:0] CHAN_CODE = 8'h7C;
    localparam logic [7:0] ESC_CODE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic       sop_pend_r;
    logic       eop_pend_r;
    logic       accept_s;
    logic       payload_s;
    logic [7:0] payload_byte_s;
    logic       mark_sop_s;
    logic       mark_eop_s;

    // Single output register: a byte may enter whenever that register is free or draining.
    assign in_ready = out_ready | ~out_valid;
    assign accept_s = in_valid & in_ready;

    // Classify the byte at the input according to the current decode state.
    always_comb begin
        state_next_s   = state_r;
        payload_s      = 1'b0;
        payload_byte_s = in_data;
        mark_sop_s     = 1'b0;
        mark_eop_s     = 1'b0;
        case (state_r)
            ST_NORMAL: begin
                case (in_data)
                    SOP_CODE:  mark_sop_s   = 1'b1;
                    EOP_CODE:  mark_eop_s   = 1'b1;
                    CHAN_CODE: state_next_s = ST_CHAN;
                    ESC_CODE:  state_next_s = ST_ESC;
                    default:   payload_s    = 1'b1;
                endcase
            end
            ST_ESC: begin
                payload_s      = 1'b1;
                payload_byte_s = in_data ^ ESC_XOR;
                state_next_s   = ST_NORMAL;
            end
            ST_CHAN: begin
                if (in_data == ESC_CODE) begin
                    state_next_s = ST_CHAN_ESC;
                end else begin
                    state_next_s = ST_NORMAL;
                end
            end
            ST_CHAN_ESC: state_next_s = ST_NORMAL;
            default:     state_next_s = ST_NORMAL;
        endcase
    end

    // Decode state and pending framing flags; a payload byte consumes both flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_NORMAL;
            sop_pend_r <= 1'b0;
            eop_pend_r <= 1'b0;
        end else if (accept_s) begin
            state_r <= state_next_s;
            if (payload_s) begin
                sop_pend_r <= 1'b0;
                eop_pend_r <= 1'b0;
            end else if (mark_sop_s) begin
                sop_pend_r <= 1'b1;
                eop_pend_r <= 1'b0;
            end else if (mark_eop_s) begin
                eop_pend_r <= 1'b1;
            end
        end
    end

    // Output beat register: reload on payload (even while draining), else clear on drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= 8'h00;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end else if (accept_s && payload_s) begin
            out_valid         <= 1'b1;
            out_data          <= payload_byte_s;
            out_startofpacket <= sop_pend_r;
            out_endofpacket   <= eop_pend_r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef KERNEL_DDR3_MEM_DMASTER_B2P_CHANNEL_EN
    logic [CHANNEL_W-1:0] chan_r;
    logic [7:0]           chan_byte_s;
    logic                 chan_load_s;

    assign chan_byte_s = (state_r == ST_CHAN_ESC) ? (in_data ^ ESC_XOR) : in_data;
    assign chan_load_s = accept_s &
                         (((state_r == ST_CHAN) && (in_data != ESC_CODE)) ||
                          (state_r == ST_CHAN_ESC));

    // Channel register persists across packets; the beat captures it on payload accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_r      <= {CHANNEL_W{1'b0}};
            out_channel <= {CHANNEL_W{1'b0}};
        end else begin
            if (chan_load_s) begin
                chan_r <= chan_byte_s[CHANNEL_W-1:0];
            end
            if (accept_s && payload_s) begin
                out_channel <= chan_r;
            end
        end
    end
`else
    assign out_channel = {CHANNEL_W{1'b0}};
`endif

endmodule

// File: tb/tb_kernel_ddr3_mem_dmaster_bytes_to_packets.sv
// Self-checking bench: directed framing/escape/channel/backpressure/reset cases plus a
// randomized 256-byte stream checked against a byte-stream decode model.
module tb_kernel_ddr3_mem_dmaster_bytes_to_packets;

    localparam int CW = 8;
`ifdef KERNEL_DDR3_MEM_DMASTER_B2P_CHANNEL_EN
    localparam bit CH_EN = 1'b1;
`else
    localparam bit CH_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_ready;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [CW-1:0] out_channel;
    logic          out_startofpacket;
    logic          out_endofpacket;

    kernel_ddr3_mem_dmaster_bytes_to_packets #(.CHANNEL_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
        .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_channel(out_channel),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic [7:0] ch;
    } beat_t;

    beat_t exp_q[$];
    beat_t log_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    bit    rand_ready = 1'b0;

    // Reference decoder state: mode 0 normal, 1 escaped payload, 2 channel, 3 escaped channel.
    int         m_mode = 0;
    logic       m_sop = 1'b0;
    logic       m_eop = 1'b0;
    logic [7:0] m_chan = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic sop, input logic eop,
                                 input logic [7:0] ch);
        beat_t b;
        b.d = d; b.sop = sop; b.eop = eop; b.ch = CH_EN ? ch : 8'h00;
        return b;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_sop = 1'b0; m_eop = 1'b0; m_chan = 8'h00;
        exp_q.delete();
    endtask

    task automatic model_emit(input logic [7:0] d);
        exp_q.push_back(mk(d, m_sop, m_eop, m_chan));
        m_sop = 1'b0;
        m_eop = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_mode == 1) begin
            model_emit(b ^ 8'h20); m_mode = 0;
        end else if (m_mode == 2) begin
            if (b == 8'h7D) m_mode = 3;
            else begin m_chan = b; m_mode = 0; end
        end else if (m_mode == 3) begin
            m_chan = b ^ 8'h20; m_mode = 0;
        end else if (b == 8'h7A) begin
            m_sop = 1'b1; m_eop = 1'b0;
        end else if (b == 8'h7B) m_eop = 1'b1;
        else if (b == 8'h7C) m_mode = 2;
        else if (b == 8'h7D) m_mode = 1;
        else model_emit(b);
    endtask

    // Handshake monitor: ready rule, drained-beat log, feed accepted bytes to the model.
    always @(posedge clk) begin
        if (reset_n) begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, out_ready | ~out_valid});
            if (out_valid && out_ready) begin
                log_q.push_back({out_data, out_startofpacket, out_endofpacket, out_channel});
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) model_byte(in_data);
        end
    end

    // Cycle compare: the output register must show exactly the model's oldest undrained beat.
    always @(negedge clk) begin
        #2;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0].d});
            chk("out_sop", {31'd0, out_startofpacket}, {31'd0, exp_q[0].sop});
            chk("out_eop", {31'd0, out_endofpacket}, {31'd0, exp_q[0].eop});
            chk("out_channel", {24'd0, out_channel}, {24'd0, exp_q[0].ch});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom % 3) != 0;
        end
    end

    // Called at a negedge; returns at the negedge following acceptance with in_valid still high.
    task automatic send(input logic [7:0] b, output int waits);
        logic acc;
        in_valid = 1'b1;
        in_data  = b;
        waits    = 0;
        while (1) begin
            #1;
            acc = in_ready;
            @(negedge clk);
            if (acc) break;
            waits++;
            if (waits > 200) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", b);
                break;
            end
        end
    endtask

    task automatic send_b(input logic [7:0] b);
        int w;
        send(b, w);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_log(input string name, input beat_t e[$]);
        chk({name, "_count"}, log_q.size(), e.size());
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            chk({name, "_beat"}, {6'd0, log_q[i]}, {6'd0, e[i]});
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int         w;
        beat_t      e[$];
        logic [7:0] pay[256];

        model_reset();
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_channel", {24'd0, out_channel}, 32'd0);
        chk("rst_sop_eop", {30'd0, out_startofpacket, out_endofpacket}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic framing
        log_q.delete();
        send_b(8'h7A); send_b(8'h01); send_b(8'h02); send_b(8'h7B); send_b(8'h03);
        idle(3);
        e = '{mk(8'h01, 1'b1, 1'b0, 8'h00), mk(8'h02, 1'b0, 1'b0, 8'h00),
              mk(8'h03, 1'b0, 1'b1, 8'h00)};
        chk_log("framing", e);

        // Channel select
        log_q.delete();
        send_b(8'h7C); send_b(8'h05); send_b(8'h7A); send_b(8'hAA); send_b(8'h7B); send_b(8'hBB);
        idle(3);
        e = '{mk(8'hAA, 1'b1, 1'b0, 8'h05), mk(8'hBB, 1'b0, 1'b1, 8'h05)};
        chk_log("channel", e);

        // Escapes in payload and channel
        log_q.delete();
        send_b(8'h7D); send_b(8'h5A); send_b(8'h7D); send_b(8'h5D);
        send_b(8'h7C); send_b(8'h7D); send_b(8'h5C); send_b(8'h11);
        idle(3);
        e = '{mk(8'h7A, 1'b0, 1'b0, 8'h05), mk(8'h7D, 1'b0, 1'b0, 8'h05),
              mk(8'h11, 1'b0, 1'b0, 8'h7C)};
        chk_log("escape", e);

        // Backpressure: beat 01 held for 4 cycles, then drain and accept in the same cycle
        log_q.delete();
        out_ready = 1'b0;
        send_b(8'h01);
        in_data = 8'h02;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_valid_data", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h01});
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(8'h02, w);
        chk("release_accept_wait", w, 32'd0);
        idle(3);
        e = '{mk(8'h01, 1'b0, 1'b0, 8'h7C), mk(8'h02, 1'b0, 1'b0, 8'h7C)};
        chk_log("backpressure", e);

        // Reset mid channel sequence
        log_q.delete();
        send_b(8'h7C);
        in_valid = 1'b0;
        chk("pre_reset_data", {24'd0, out_data}, 32'h02);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'd0);
        chk("mid_rst_channel", {24'd0, out_channel}, 32'd0);
        chk("mid_rst_sop_eop", {30'd0, out_startofpacket, out_endofpacket}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_b(8'h7A); send_b(8'h44);
        idle(3);
        e = '{mk(8'h44, 1'b1, 1'b0, 8'h00)};
        chk_log("after_reset", e);

        // Randomized stream of 256 payload bytes under random out_ready
        log_q.delete();
        rand_ready = 1'b1;
        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
        send_b(8'h7A);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) send_b(8'h7B);
            if (pay[i] >= 8'h7A && pay[i] <= 8'h7D) begin
                send_b(8'h7D);
                send_b(pay[i] ^ 8'h20);
            end else begin
                send_b(pay[i]);
            end
            if (($urandom % 5) == 0) idle(1);
        end
        idle(1);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle(5);
        chk("random_count", log_q.size(), 32'd256);
        for (int i = 0; i < 256 && i < log_q.size(); i++)
            chk("random_data", {24'd0, log_q[i].d}, {24'd0, pay[i]});
        if (log_q.size() == 256) begin
            chk("random_first_sop", {31'd0, log_q[0].sop}, 32'd1);
            chk("random_last_eop", {31'd0, log_q[255].eop}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_ddr3_mem_dmaster_bytes_to_packets.md
KERNEL_DDR3_MEM_DMASTER_BYTES_TO_PACKETS -- requirements
Module: kernel_ddr3_mem_dmaster_bytes_to_packets

Interface
REQ-001 SHALL have parameter CHANNEL_W, default 8, width of out_channel (1..8); received channel byte truncated to low CHANNEL_W bits.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_ready  output  1  byte-stream sink ready.
REQ-005 SHALL have port in_valid  input  1  byte valid.
REQ-006 SHALL have port in_data  input  8  encoded byte.
REQ-007 SHALL have port out_ready  input  1  downstream (channel adapter) ready.
REQ-008 SHALL have port out_valid  output  1  packet beat valid.
REQ-009 SHALL have port out_data  output  8  decoded payload byte.
REQ-010 SHALL have port out_channel  output  CHANNEL_W  current channel.
REQ-011 SHALL have ports out_startofpacket, out_endofpacket  output  1 each  packet framing.

Function
REQ-012 SHALL accept a byte when in_valid & in_ready; in_ready SHALL equal out_ready | ~out_valid (single output register, combinational ready).
REQ-013 SHALL decode in state NORMAL: 0x7A -> set sop_pend, clear eop_pend, no output; 0x7B -> set eop_pend, no output; 0x7C -> go CHAN; 0x7D -> go ESC; any other byte -> payload.
REQ-014 SHALL in ESC treat the next accepted byte (any value, including specials) as payload equal to byte XOR 0x20, then return to NORMAL.
REQ-015 SHALL in CHAN: 0x7D -> go CHAN_ESC; any other byte -> channel register = byte, return to NORMAL, no output.
REQ-016 SHALL in CHAN_ESC load channel register = byte XOR 0x20, return to NORMAL, no output.
REQ-017 SHALL on payload load out_data, out_channel = channel register, out_startofpacket = sop_pend, out_endofpacket = eop_pend, set out_valid, and clear sop_pend and eop_pend, all on the accepting edge (latency 1 cycle).
REQ-018 SHALL clear out_valid on out_valid & out_ready when no payload is accepted in the same cycle; simultaneous drain and payload accept SHALL reload the register with no bubble.
REQ-019 SHALL hold all out_* stable while out_valid & ~out_ready.
REQ-020 SHALL retain the channel register across packets until a new channel sequence is decoded.
REQ-021 SHALL treat repeated 0x7A/0x7B markers idempotently; an 0x7B before 0x7A SHALL still flag the next payload EOP.
REQ-022 SHALL consume marker/escape/channel bytes without asserting out_valid; such bytes SHALL be accepted under the same in_ready rule.

Reset
REQ-023 SHALL on reset_n low, asynchronously: state = NORMAL, sop_pend = 0, eop_pend = 0, channel register = 0, out_valid = 0, out_data = 0, out_channel = 0, out_startofpacket = 0, out_endofpacket = 0.
REQ-024 SHALL drop any partial escape/channel sequence and held beat on reset mid-operation; first byte after release decoded in NORMAL.

Configuration
REQ-025 SHALL support macro KERNEL_DDR3_MEM_DMASTER_B2P_CHANNEL_EN: defined -> channel decoding per REQ-015/016; undefined -> CHAN/CHAN_ESC still consume the channel byte (and its escape) but channel register stays 0 and out_channel is tied 0.

Verification
REQ-026 SHALL test: bytes 7A 01 02 7B 03, out_ready=1 -> beats 01(SOP=1), 02, 03(EOP=1), channel 0, each 1 cycle after acceptance.
REQ-027 SHALL test: bytes 7C 05 7A AA 7B BB with macro defined -> AA ch=5 SOP, BB ch=5 EOP; macro undefined -> same beats with ch=0.
REQ-028 SHALL test: bytes 7D 5A 7D 5D 7C 7D 5C 11 -> beats 7A, 7D, then 11 with channel 0x7C.
REQ-029 SHALL test: out_ready held 0 for 4 cycles with beat 01 pending -> in_ready=0, out_* stable; release -> 01 drains, next byte accepted same cycle, no loss or duplication.
REQ-030 SHALL test: reset_n pulsed low after 7C (mid channel) -> outputs zero immediately; next bytes 7A 44 -> 44 SOP=1 ch=0.
REQ-031 SHALL test: back-to-back 256 random payload bytes with random out_ready -> output sequence equals decoded reference model, zero drops.
